// File: rtl/multi_channel_frequency_analyzer.sv
// Multi-channel pixel-stream frequency analyzer: samples bit 7 at per-channel pixel indices,
// measures rising-edge periods, accumulates in-band time for two bands and dumps the results.
module multi_channel_frequency_analyzer #(
  parameter int unsigned CHANNELS          = 3,
  parameter int unsigned PIXEL_INDEX_WIDTH = 10,
  parameter int unsigned PERIOD_WIDTH      = 24,
  parameter int unsigned ACC_WIDTH         = 32,
  parameter int unsigned INDEX_WIDTH       = 5
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [7:0]                          data,
  input  logic                                pixel_valid,
  input  logic                                line_start,
  input  logic [CHANNELS*PIXEL_INDEX_WIDTH-1:0] pixel_index,
  input  logic [CHANNELS*4*PERIOD_WIDTH-1:0]  band_limits,
  input  logic                                start,
  input  logic                                stop,
  input  logic                                clear,
  output logic                                busy,
  output logic                                result_valid,
  input  logic                                result_ready,
  output logic [INDEX_WIDTH-1:0]              result_index,
  output logic [ACC_WIDTH-1:0]                result_data,
  output logic                                irq
);

  typedef enum logic [1:0] {StIdle, StRun, StDump, StDone} state_e;

  localparam int unsigned SumW = ((ACC_WIDTH > PERIOD_WIDTH) ? ACC_WIDTH : PERIOD_WIDTH) + 1;
  localparam logic [ACC_WIDTH-1:0]    AccMax    = '1;
  localparam logic [PERIOD_WIDTH-1:0] PeriodMax = '1;
  localparam logic [INDEX_WIDTH-1:0]  LastWord  = INDEX_WIDTH'(2 * CHANNELS - 1);

  state_e                       state_q;
  logic [PIXEL_INDEX_WIDTH-1:0] pix_cnt_q;
  logic [PIXEL_INDEX_WIDTH-1:0] cur_idx;
  logic [CHANNELS-1:0]          sample_q, sample_d_q, rise, rise_q, arm_q;
  logic [CHANNELS-1:0]          in_b0, in_b1;
  logic [PERIOD_WIDTH-1:0]      period_q [CHANNELS];
  logic [PERIOD_WIDTH-1:0]      rise_p_q [CHANNELS];
  logic [ACC_WIDTH-1:0]         acc0_q   [CHANNELS];
  logic [ACC_WIDTH-1:0]         acc1_q   [CHANNELS];
  logic [INDEX_WIDTH-1:0]       next_k;
  logic [ACC_WIDTH-1:0]         next_word;

  logic unused_data;
  assign unused_data = ^data[6:0];

  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [PERIOD_WIDTH-1:0] p);
    logic [SumW-1:0] s;
    s = SumW'(a) + SumW'(p);
    if (s > SumW'(AccMax)) return AccMax;
    return s[ACC_WIDTH-1:0];
  endfunction

  assign busy    = (state_q != StIdle);
  assign cur_idx = line_start ? '0 : pix_cnt_q;
  assign rise    = sample_q & ~sample_d_q;

  // Band classification of the period captured with the registered edge
  always_comb begin
    in_b0 = '0;
    in_b1 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      in_b0[c] = (rise_p_q[c] >= band_limits[(4*c)*PERIOD_WIDTH +: PERIOD_WIDTH]) &&
                 (rise_p_q[c] <= band_limits[(4*c+1)*PERIOD_WIDTH +: PERIOD_WIDTH]);
      in_b1[c] = (rise_p_q[c] >= band_limits[(4*c+2)*PERIOD_WIDTH +: PERIOD_WIDTH]) &&
                 (rise_p_q[c] <= band_limits[(4*c+3)*PERIOD_WIDTH +: PERIOD_WIDTH]);
    end
  end

  // Word to present after the current one (word 0 when leaving RUN)
  always_comb begin
    next_k    = (state_q == StRun) ? '0 : result_index + INDEX_WIDTH'(1);
    next_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (next_k == INDEX_WIDTH'(2*c))     next_word = acc0_q[c];
      if (next_k == INDEX_WIDTH'(2*c + 1)) next_word = acc1_q[c];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_cnt_q  <= '0;
      sample_q   <= '0;
      sample_d_q <= '0;
      rise_q     <= '0;
      arm_q      <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        period_q[c] <= '0;
        rise_p_q[c] <= '0;
        acc0_q[c]   <= '0;
        acc1_q[c]   <= '0;
      end
    end else begin
      sample_d_q <= sample_q;
      if (clear) begin
        rise_q <= '0;
        arm_q  <= '0;
        for (int c = 0; c < CHANNELS; c++) begin
          acc0_q[c] <= '0;
          acc1_q[c] <= '0;
        end
      end else if (state_q == StIdle && start) begin
        pix_cnt_q <= '0;
        rise_q    <= '0;
        arm_q     <= '0;
        for (int c = 0; c < CHANNELS; c++) begin
          period_q[c] <= '0;
          acc0_q[c]   <= '0;
          acc1_q[c]   <= '0;
        end
      end else if (state_q == StRun) begin
        if (pixel_valid) begin
          pix_cnt_q <= cur_idx + PIXEL_INDEX_WIDTH'(1);
          for (int c = 0; c < CHANNELS; c++) begin
            if (cur_idx == pixel_index[c*PIXEL_INDEX_WIDTH +: PIXEL_INDEX_WIDTH]) begin
              sample_q[c] <= data[7];
            end
          end
        end
        for (int c = 0; c < CHANNELS; c++) begin
          rise_q[c]   <= rise[c];
          rise_p_q[c] <= period_q[c];
          if (rise[c]) begin
            period_q[c] <= PERIOD_WIDTH'(1);
          end else if (period_q[c] != PeriodMax) begin
            period_q[c] <= period_q[c] + PERIOD_WIDTH'(1);
          end
          // The first edge only marks the start of a period
          if (rise_q[c]) begin
            if (!arm_q[c]) begin
              arm_q[c] <= 1'b1;
            end else if (rise_p_q[c] != PeriodMax) begin
              if (in_b0[c])      acc0_q[c] <= sat_add(acc0_q[c], rise_p_q[c]);
              else if (in_b1[c]) acc1_q[c] <= sat_add(acc1_q[c], rise_p_q[c]);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      result_valid <= 1'b0;
      result_index <= '0;
      result_data  <= '0;
      irq          <= 1'b0;
    end else if (clear) begin
      state_q      <= StIdle;
      result_valid <= 1'b0;
      result_index <= '0;
      result_data  <= '0;
      irq          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          irq <= 1'b0;
          if (start) state_q <= StRun;
        end
        StRun: begin
          if (stop) begin
            state_q      <= StDump;
            result_valid <= 1'b1;
            result_index <= next_k;
            result_data  <= next_word;
          end
        end
        StDump: begin
          if (result_ready) begin
            if (result_index == LastWord) begin
              state_q      <= StDone;
              result_valid <= 1'b0;
              irq          <= 1'b1;
            end else begin
              result_index <= next_k;
              result_data  <= next_word;
            end
          end
        end
        StDone: begin
          irq     <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_channel_frequency_analyzer.sv
// Scoreboard bench: stimulus pushes expected dump words, a negedge monitor pops and compares.
module tb_multi_channel_frequency_analyzer;
  localparam int unsigned CH = 3, PIW = 10, PW = 24;

  logic clock = 1'b0;
  logic reset;
  logic [7:0] data;
  logic pixel_valid, line_start, start, stop, clear, result_ready, s_start;
  logic [CH*PIW-1:0] pixel_index;
  logic [CH*4*PW-1:0] band_limits;
  logic busy, result_valid, irq;
  logic [4:0] result_index;
  logic [31:0] result_data;
  logic s_busy, s_valid, s_irq;
  logic [4:0] s_index;
  logic [7:0] s_data;
  logic [PIW-1:0] s_pixel_index;
  logic [4*PW-1:0] s_band;

  multi_channel_frequency_analyzer dut (
    .clock(clock), .reset(reset), .data(data), .pixel_valid(pixel_valid),
    .line_start(line_start), .pixel_index(pixel_index), .band_limits(band_limits),
    .start(start), .stop(stop), .clear(clear), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_index(result_index), .result_data(result_data),
    .irq(irq)
  );

  multi_channel_frequency_analyzer #(.CHANNELS(1), .ACC_WIDTH(8)) dut_small (
    .clock(clock), .reset(reset), .data(data), .pixel_valid(pixel_valid),
    .line_start(line_start), .pixel_index(s_pixel_index), .band_limits(s_band),
    .start(s_start), .stop(stop), .clear(clear), .busy(s_busy), .result_valid(s_valid),
    .result_ready(result_ready), .result_index(s_index), .result_data(s_data), .irq(s_irq)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int fails = 0;
  int irq_cnt = 0;
  int unsigned q_idx[$], q_data[$], s_q[$];
  bit last_acc_prev = 0, irq_prev = 0, hold_pend = 0;
  logic [4:0] hold_idx;
  logic [31:0] hold_data;
  logic [63:0] e_i, e_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idx(input int c, input int v);
    pixel_index[c*PIW +: PIW] = PIW'(v);
  endtask

  task automatic set_bands(input int c, input int b0lo, input int b0hi, input int b1lo,
                           input int b1hi);
    band_limits[(4*c)*PW +: PW]   = PW'(b0lo);
    band_limits[(4*c+1)*PW +: PW] = PW'(b0hi);
    band_limits[(4*c+2)*PW +: PW] = PW'(b1lo);
    band_limits[(4*c+3)*PW +: PW] = PW'(b1hi);
  endtask

  task automatic begin_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Lines of `len` pixels; bit 7 follows line parity so every sampled channel
  // sees one rising edge per two lines.
  task automatic run_stream(input int len, input int nlines, input bit ls);
    for (int ln = 0; ln < nlines; ln++) begin
      for (int i = 0; i < len; i++) begin
        pixel_valid = 1'b1;
        line_start  = ls && (i == 0);
        data        = (ln % 2 == 1) ? 8'hD5 : 8'h55;
        tick();
      end
    end
    pixel_valid = 1'b0;
    line_start  = 1'b0;
    data        = 8'h00;
    repeat (5) tick();
  endtask

  task automatic dump6(input int unsigned e0, input int unsigned e1, input int unsigned e2,
                       input int unsigned e3, input int unsigned e4, input int unsigned e5,
                       input bit stall);
    int irq0;
    q_idx.push_back(0); q_data.push_back(e0);
    q_idx.push_back(1); q_data.push_back(e1);
    q_idx.push_back(2); q_data.push_back(e2);
    q_idx.push_back(3); q_data.push_back(e3);
    q_idx.push_back(4); q_data.push_back(e4);
    q_idx.push_back(5); q_data.push_back(e5);
    irq0 = irq_cnt;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int c = 0; c < 14; c++) begin
      result_ready = !(stall && c >= 2 && c < 5);
      tick();
    end
    result_ready = 1'b1;
    check("dump_drained", q_idx.size(), 0);
    check("irq_count", irq_cnt - irq0, 1);
    check("busy_after_dump", busy, 0);
  endtask

  // Main DUT monitor
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (hold_pend && result_valid) begin
          check("hold_index", result_index, hold_idx);
          check("hold_data", result_data, hold_data);
        end
        if (irq || last_acc_prev) check("irq_timing", irq, last_acc_prev);
        if (irq) irq_cnt++;
        if (irq_prev) check("busy_fall", busy, 0);
        if (result_valid && result_ready) begin
          if (q_idx.size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL unexpected_word: got index %0d data %0d, expected none",
                     result_index, result_data);
          end else begin
            e_i = q_idx.pop_front();
            e_d = q_data.pop_front();
            check("word_index", result_index, e_i);
            check("word_data", result_data, e_d);
          end
        end
        hold_pend     = result_valid && !result_ready;
        hold_idx      = result_index;
        hold_data     = result_data;
        last_acc_prev = result_valid && result_ready && (result_index == 5'd5);
        irq_prev      = irq;
      end
    end
  end

  // Narrow-accumulator DUT monitor
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && s_valid && result_ready) begin
        if (s_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL small_unexpected: got data %0d, expected none", s_data);
        end else begin
          e_d = s_q.pop_front();
          check("small_word", s_data, e_d);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; data = 8'h00; pixel_valid = 1'b0; line_start = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; result_ready = 1'b1; s_start = 1'b0;
    pixel_index = '0; band_limits = '0;
    s_pixel_index = PIW'(15);
    s_band = {24'd300, 24'd200, 24'd110, 24'd90};
    set_idx(0, 15); set_idx(1, 1000); set_idx(2, 1001);
    for (int c = 0; c < 3; c++) set_bands(c, 990, 1010, 1900, 2100);
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_index", result_index, 0);
    check("rst_data", result_data, 0);
    check("rst_small_busy", s_busy, 0);
    reset = 1'b0;
    tick();

    // Channel 0 period 1000 in band0, with backpressure on word 2
    begin_run();
    run_stream(500, 10, 1);
    dump6(4000, 0, 0, 0, 0, 0, 1);

    // Channel 1 period 2000: band1, then overlapping bands where band0 wins
    set_idx(0, 1000); set_idx(1, 15);
    begin_run();
    run_stream(1000, 8, 1);
    dump6(0, 0, 0, 6000, 0, 0, 0);
    set_bands(1, 1500, 2500, 1900, 2100);
    begin_run();
    run_stream(1000, 8, 1);
    dump6(0, 0, 6000, 0, 0, 0, 0);

    // Period 5000 on every channel, outside all bands
    set_bands(1, 990, 1010, 1900, 2100);
    set_idx(0, 1000); set_idx(1, 1001); set_idx(2, 15);
    begin_run();
    run_stream(2500, 6, 1);
    dump6(0, 0, 0, 0, 0, 0, 0);

    // Free-running pixel counter wrap: index 1023 hit every 1024 pixels
    set_idx(0, 1023);
    set_bands(0, 990, 1010, 2040, 2060);
    set_bands(1, 990, 1010, 3000, 3100);
    set_bands(2, 990, 1010, 3000, 3100);
    begin_run();
    run_stream(1024, 6, 0);
    dump6(0, 4096, 0, 0, 0, 0, 0);

    // Period 100 band0: 500 on the wide DUT, saturates to 255 on the 8-bit one
    set_idx(0, 15); set_idx(1, 1000); set_idx(2, 1001);
    set_bands(0, 90, 110, 200, 300);
    start = 1'b1; s_start = 1'b1;
    tick();
    start = 1'b0; s_start = 1'b0;
    run_stream(50, 12, 1);
    s_q.push_back(255);
    s_q.push_back(0);
    dump6(500, 0, 0, 0, 0, 0, 0);
    check("small_drained", s_q.size(), 0);

    // clear in the middle of a dump
    set_bands(0, 990, 1010, 1900, 2100);
    begin_run();
    run_stream(500, 4, 1);
    q_idx.push_back(0); q_data.push_back(1000);
    q_idx.push_back(1); q_data.push_back(0);
    q_idx.push_back(2); q_data.push_back(0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    check("pre_clear_index", result_index, 3);
    result_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    result_ready = 1'b1;
    check("clear_valid", result_valid, 0);
    check("clear_busy", busy, 0);
    check("clear_irq", irq, 0);
    begin
      int irq0;
      irq0 = irq_cnt;
      repeat (3) tick();
      check("clear_no_irq", irq_cnt - irq0, 0);
    end
    check("clear_drained", q_idx.size(), 0);

    // start and stop together in IDLE enter RUN, not DUMP
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 1);
    check("startstop_valid", result_valid, 0);
    tick();
    check("run_no_valid", result_valid, 0);
    dump6(0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset while running
    begin_run();
    repeat (3) tick();
    check("run_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_valid", result_valid, 0);
    check("async_irq", irq, 0);
    check("async_index", result_index, 0);
    check("async_data", result_data, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
